// File: rtl/decode_div_pkg.sv
// decode_div_pkg: shared widths, saturation limits and FSM states for the signed divider
package decode_div_pkg;
   localparam int D0W = 70;
   localparam int D1W = 31;
   localparam int DQW = 40;
   localparam logic [DQW-1:0] QMAX = {1'b0, {(DQW-1){1'b1}}};
   localparam logic [DQW-1:0] QMIN = {1'b1, {(DQW-1){1'b0}}};
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/decode_sdiv_step.sv
// decode_sdiv_step: one restoring-division bit (shift in, compare, conditional subtract)
module decode_sdiv_step #(
   parameter int W = 31
) (
   input  logic [W-1:0] r_in,
   input  logic         b_in,
   input  logic [W-1:0] d,
   output logic [W-1:0] r_out,
   output logic         q
);
   logic [W:0] shifted;
   logic [W:0] dv;
   // partial remainder stays below the divisor, so W bits always hold the result
   always_comb begin
      shifted = {r_in, b_in};
      dv      = {1'b0, d};
      q       = shifted >= dv;
      r_out   = q ? W'(shifted - dv) : shifted[W-1:0];
   end
endmodule

// File: rtl/decode_sdiv_70s_31s_40_seq.sv
// decode_sdiv_70s_31s_40_seq: sequential signed divider with saturating quotient
module decode_sdiv_70s_31s_40_seq
   import decode_div_pkg::*;
#(
   parameter int ID         = 1,
   parameter int din0_WIDTH = D0W,
   parameter int din1_WIDTH = D1W,
   parameter int dout_WIDTH = DQW
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  start,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  ready,
   output logic                  done,
   output logic [dout_WIDTH-1:0] dout,
   output logic [din1_WIDTH-1:0] rem,
   output logic                  ovf,
   output logic                  dz
);
   localparam int CW = $clog2(din0_WIDTH + 1);
   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [din0_WIDTH-1:0] a_q, a_d;
   logic [din1_WIDTH-1:0] d_q, d_d, r_q, r_d, r_nxt;
   logic                  s0_q, s0_d, s1_q, s1_d, q_bit;
   logic [dout_WIDTH-1:0] dout_q, dout_d, q_lo;
   logic [din1_WIDTH-1:0] rem_q, rem_d;
   logic                  ovf_q, ovf_d, dz_q, dz_d;
   logic                  neg, over, zero;

   decode_sdiv_step #(.W(din1_WIDTH)) u_step (
      .r_in (r_q),
      .b_in (a_q[din0_WIDTH-1]),
      .d    (d_q),
      .r_out(r_nxt),
      .q    (q_bit)
   );

   assign neg   = s0_q ^ s1_q;
   assign zero  = d_q == '0;
   assign over  = a_q > (din0_WIDTH'(QMAX) + din0_WIDTH'(neg));
   assign q_lo  = neg ? -a_q[dout_WIDTH-1:0] : a_q[dout_WIDTH-1:0];
   assign ready = state_q == IDLE;
   assign done  = state_q == DONE;
   assign dout  = dout_q;
   assign rem   = rem_q;
   assign ovf   = ovf_q;
   assign dz    = dz_q;

   // next state: capture magnitudes, iterate one bit per cycle, then apply signs and saturation
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      d_d     = d_q;
      r_d     = r_q;
      s0_d    = s0_q;
      s1_d    = s1_q;
      dout_d  = dout_q;
      rem_d   = rem_q;
      ovf_d   = ovf_q;
      dz_d    = dz_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = CALC;
            cnt_d   = '0;
            a_d     = din0[din0_WIDTH-1] ? -din0 : din0;
            d_d     = din1[din1_WIDTH-1] ? -din1 : din1;
            r_d     = '0;
            s0_d    = din0[din0_WIDTH-1];
            s1_d    = din1[din1_WIDTH-1];
         end
         CALC: begin
            a_d     = {a_q[din0_WIDTH-2:0], q_bit};
            r_d     = r_nxt;
            cnt_d   = cnt_q + CW'(1);
            state_d = (cnt_q == CW'(din0_WIDTH - 1)) ? FIX : CALC;
         end
         FIX: begin
            state_d = DONE;
            dz_d    = zero;
            ovf_d   = !zero && over;
            dout_d  = (zero || over) ? (((zero ? s0_q : neg)) ? dout_WIDTH'(QMIN) : dout_WIDTH'(QMAX)) : q_lo;
            rem_d   = zero ? '0 : s0_q ? -r_q : r_q;
         end
         default: state_d = IDLE;
      endcase
   end

   // state register: active-low reset wins over ce, otherwise advance only on ce-high edges
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         d_q     <= '0;
         r_q     <= '0;
         s0_q    <= 1'b0;
         s1_q    <= 1'b0;
         dout_q  <= '0;
         rem_q   <= '0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else if (ce) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         d_q     <= d_d;
         r_q     <= r_d;
         s0_q    <= s0_d;
         s1_q    <= s1_d;
         dout_q  <= dout_d;
         rem_q   <= rem_d;
         ovf_q   <= ovf_d;
         dz_q    <= dz_d;
      end
   end
endmodule

// File: tb/tb_decode_sdiv_70s_31s_40_seq.sv
// tb_decode_sdiv_70s_31s_40_seq: directed and random checks against an arithmetic reference
module tb_decode_sdiv_70s_31s_40_seq;
   localparam logic [39:0]        Q_HI = 40'h7F_FFFF_FFFF;
   localparam logic [39:0]        Q_LO = 40'h80_0000_0000;
   localparam logic signed [71:0] S_HI = 72'sd549755813887;
   localparam logic signed [71:0] S_LO = -72'sd549755813888;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ce = 1'b0;
   logic        start = 1'b0;
   logic [69:0] din0 = '0;
   logic [30:0] din1 = '0;
   logic        ready, done, ovf, dz;
   logic [39:0] dout;
   logic [30:0] rem;
   int          n_chk = 0;
   int          n_pass = 0;

   decode_sdiv_70s_31s_40_seq dut (
      .clk  (clk),
      .reset(reset),
      .ce   (ce),
      .start(start),
      .din0 (din0),
      .din1 (din1),
      .ready(ready),
      .done (done),
      .dout (dout),
      .rem  (rem),
      .ovf  (ovf),
      .dz   (dz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic logic [69:0] rnd70();
      return 70'({$urandom, $urandom, $urandom});
   endfunction

   // reference: truncating signed division on wide integers, then the saturation rule
   function automatic void model(input logic [69:0] a, input logic [30:0] b,
                                 output logic [39:0] q, output logic [30:0] r,
                                 output logic o, output logic z);
      logic signed [71:0] sa, sb, sq, sr;
      sa = {{2{a[69]}}, a};
      sb = {{41{b[30]}}, b};
      z = b == '0;
      o = 1'b0;
      q = '0;
      r = '0;
      if (z) q = a[69] ? Q_LO : Q_HI;
      else begin
         sq = sa / sb;
         sr = sa % sb;
         r = sr[30:0];
         if (sq > S_HI) begin o = 1'b1; q = Q_HI; end
         else if (sq < S_LO) begin o = 1'b1; q = Q_LO; end
         else q = sq[39:0];
      end
   endfunction

   task automatic do_op(input logic [69:0] a, input logic [30:0] b, input int gap,
                        input bit hold, input bit done_ce);
      logic [39:0] eq;
      logic [30:0] er;
      logic        eo, ez;
      int          cyc;
      bit          seen;
      model(a, b, eq, er, eo, ez);
      @(negedge clk);
      chk("ready_idle", 70'(ready), 70'(1));
      start = 1'b1;
      din0 = a;
      din1 = b;
      ce = 1'b1;
      @(posedge clk);
      cyc = 0;
      seen = 1'b0;
      while (!seen && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (done) seen = 1'b1;
         else begin
            if (cyc == 1) chk("busy_ready", 70'(ready), 70'(0));
            start = hold;
            if (hold) begin din0 = rnd70(); din1 = 31'($urandom); end
            ce = !(gap > 0 && cyc >= gap && cyc < gap + 10);
         end
      end
      start = 1'b0;
      chk("latency", 70'(cyc), 70'(gap > 0 ? 82 : 72));
      chk("dout", 70'(dout), 70'(eq));
      chk("rem", 70'(rem), 70'(er));
      chk("ovf", 70'(ovf), 70'(eo));
      chk("dz", 70'(dz), 70'(ez));
      if (done_ce) begin
         ce = 1'b0;
         repeat (3) @(negedge clk);
         chk("done_hold", 70'(done), 70'(1));
         ce = 1'b1;
      end
      @(negedge clk);
      chk("done_pulse", 70'(done), 70'(0));
      chk("ready_after", 70'(ready), 70'(1));
      chk("dout_stable", 70'(dout), 70'(eq));
   endtask

   initial begin
      logic [69:0] a;
      logic [30:0] b;
      bit          seen;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 70'(ready), 70'(1));
      chk("rst_done", 70'(done), 70'(0));
      chk("rst_dout", 70'(dout), 70'(0));
      chk("rst_rem", 70'(rem), 70'(0));
      reset = 1'b1;
      ce = 1'b1;
      do_op(70'd100, 31'd7, 0, 1'b0, 1'b0);
      do_op(-70'sd100, 31'd7, 0, 1'b0, 1'b0);
      do_op(70'd100, -31'sd7, 0, 1'b0, 1'b0);
      do_op(70'd5, 31'd0, 0, 1'b0, 1'b0);
      do_op(-70'sd5, 31'd0, 0, 1'b0, 1'b0);
      do_op(70'd1 << 45, 31'd1, 0, 1'b0, 1'b0);
      do_op(70'd1 << 69, -31'sd1, 0, 1'b0, 1'b0);
      do_op(70'h1F_FFFF_FFFF_FFFF_FFFF, 31'h4000_0000, 0, 1'b0, 1'b0);
      do_op(70'd123456789, 31'd1000, 30, 1'b0, 1'b0);
      do_op(-70'sd987654321, 31'd77, 0, 1'b1, 1'b0);
      do_op(70'd4242, -31'sd3, 0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         a = rnd70() >> $urandom_range(0, 69);
         if ($urandom_range(0, 1) == 1) a = -a;
         b = 31'($urandom) >> $urandom_range(0, 30);
         if ($urandom_range(0, 7) == 0) b = '0;
         do_op(a, b, (i % 4 == 0) ? 40 : 0, 1'b0, 1'b0);
      end
      @(negedge clk);
      start = 1'b1;
      din0 = 70'd999999;
      din1 = 31'd13;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_ready", 70'(ready), 70'(1));
      chk("mid_rst_done", 70'(done), 70'(0));
      chk("mid_rst_dout", 70'(dout), 70'(0));
      chk("mid_rst_rem", 70'(rem), 70'(0));
      chk("mid_rst_ovf", 70'(ovf), 70'(0));
      chk("mid_rst_dz", 70'(dz), 70'(0));
      reset = 1'b1;
      seen = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("no_done", 70'(seen), 70'(0));
      do_op(70'd1000, 31'd10, 0, 1'b0, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
